spi_master: RTL and testbench
=============================

// Module: spi_master
// PURPOSE
//  Initiator end of the team SPI link. Converts a parallel byte request into one
//  framed 8-bit SPI transaction toward the SPI slave. Drives sclk/select/write_en/
//  read_en/MOSI and collects MISO. Sits between a host register interface and the
//  off-block SPI pins.
// PARAMETERS
//  CLK_DIV    2   sclk half-period in clk cycles; legal range >=1
//  FRAME_BITS 8   bits per frame; fixed, matches the slave's 3-bit counters
// PORTS
//  clk       in   1  system clock
//  rst_n     in   1  reset, asynchronous, active-low
//  start     in   1  request a frame; accepted only when busy=0
//  wr_req    in   1  frame carries tx_data to slave (drives write_en)
//  rd_req    in   1  frame collects slave data (drives read_en)
//  tx_data   in   8  byte to send, MSB first
//  busy      out  1  frame in progress
//  done      out  1  one-clk pulse at end of frame
//  rx_data   out  8  received byte, LSB first on the wire; valid from done
//  sclk      out  1  SPI clock, idle low
//  select    out  1  slave select, active-high
//  write_en  out  1  slave MOSI-capture enable
//  read_en   out  1  slave MISO-drive enable
//  MOSI      out  1  serial data to slave
//  MISO      in   1  serial data from slave
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0, state IDLE, internal regs 0. Takes effect
//   immediately mid-frame; no partial done/rx_data update.
//  Slave contract: slave samples MOSI on sclk rise; updates MISO on sclk rise.
//   So master changes MOSI only while sclk low and samples MISO on each sclk fall.
//  Accept: cycle T0 with start=1, busy=0 latches tx_data, wr_req, rd_req; start
//   while busy=1 is ignored (no queueing).
//  States: IDLE -> SETUP -> LOW/HIGH x8 bits -> FLUSH -> IDLE.
//   SETUP (T1): busy=1, select=1, write_en=wr_req, read_en=rd_req, MOSI=tx[7], sclk=0.
//   Every CLK_DIV clks sclk toggles. Rise k (k=0..7): slave takes MOSI=tx[7-k].
//   Fall k: master shifts rx[k]<=MISO (slave drives data_in[k]); MOSI<=tx[6-k].
//   Fall 7: write_en=0, read_en=0, MOSI=0.
//   FLUSH: one extra sclk rise with select=1, enables low -> slave counters clear.
//   Flush fall (T1+18*CLK_DIV): select=0, sclk=0, busy=0, done=1 for one clk;
//   rx_data updated that cycle only if rd_req latched, else holds.
//  Latency: done asserts 18*CLK_DIV+1 clks after accept. Next start accepted the
//   cycle after done (busy already 0 in done cycle; start then also accepted).
//  wr_req=rd_req=0: frame still runs (select + flush only); rx_data unchanged.
//  sclk glitch-free: sourced from a flop, never combinational.
//  Half-period counter wraps at CLK_DIV-1; CLK_DIV=1 gives sclk=clk/2.
//  Bit counter 3 bits, wraps 7->0 exactly once per frame at FLUSH entry.
// STRUCTURE
//  spi_pkg: state encoding (IDLE,SETUP,LOW,HIGH,FLUSH), FRAME_BITS=8.
//  Sub-module spi_clk_gen: half-period counter, outputs 1-clk 'tick' every
//   CLK_DIV clks while enabled; cleared on rst_n=0 or disable.
//  spi_master: FSM, tx/rx shift registers, bit counter, output flops.
// TESTING (bench instantiates spi_master + spi slave model, CLK_DIV=2)
//  1 wr: tx=8'hA5, wr_req=1 -> slave data_out=8'hA5; done at accept+37 clks.
//  2 rd: slave data_in=8'h3C, rd_req=1 -> rx_data=8'h3C at done.
//  3 full-duplex: tx=8'h81, data_in=8'h7E, both req -> slave 8'h81, rx 8'h7E;
//    repeat back-to-back 3 frames, all correct (flush realigns counters).
//  4 start while busy=1 at mid-frame -> ignored; exactly one done; tx unchanged.
//  5 rst_n low at bit 4 -> all outputs 0 same clk; next frame tx=8'hFF ok.
//  6 CLK_DIV=1 rerun of test 3 -> done at accept+19 clks, data correct.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI initiator: frame size and FSM state encoding.
package spi_pkg;

  localparam int unsigned FRAME_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOW,
    ST_HIGH,
    ST_FLUSH
  } spi_state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer for the SPI clock: one-cycle tick every CLK_DIV clks while enabled.
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Count clks within a half period; restart on wrap or whenever disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/spi_master.sv
// SPI initiator: frames one byte (MSB-first out, LSB-first in) plus a flush clock.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned FRAME_BITS = spi_pkg::FRAME_BITS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       wr_req,
  input  logic       rd_req,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       sclk,
  output logic       select,
  output logic       write_en,
  output logic       read_en,
  output logic       MOSI,
  input  logic       MISO
);

  spi_state_e r_state;
  logic [7:0] r_tx_sh;
  logic [7:0] r_rx_sh;
  logic [7:0] r_rx_data;
  logic [2:0] r_bit_cnt;
  logic       r_wr;
  logic       r_rd;
  logic       r_busy;
  logic       r_done;
  logic       r_sclk;
  logic       r_select;
  logic       r_write_en;
  logic       r_read_en;
  logic       r_mosi;

  logic       w_clk_en;
  logic       w_tick;

  assign w_clk_en = (r_state != ST_IDLE);

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_clk_en),
    .o_tick(w_tick)
  );

  // Frame sequencer: accept, shift bits on sclk edges, flush clock, then done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
      r_bit_cnt  <= '0;
      r_wr       <= 1'b0;
      r_rd       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sclk     <= 1'b0;
      r_select   <= 1'b0;
      r_write_en <= 1'b0;
      r_read_en  <= 1'b0;
      r_mosi     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_tx_sh    <= {tx_data[6:0], 1'b0};
            r_rx_sh    <= '0;
            r_wr       <= wr_req;
            r_rd       <= rd_req;
            r_bit_cnt  <= '0;
            r_busy     <= 1'b1;
            r_select   <= 1'b1;
            r_write_en <= wr_req;
            r_read_en  <= rd_req;
            r_mosi     <= tx_data[7];
            r_sclk     <= 1'b0;
            r_state    <= ST_SETUP;
          end
        end
        ST_SETUP, ST_LOW: begin
          if (w_tick) begin
            r_sclk  <= 1'b1;
            r_state <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (w_tick) begin
            r_sclk    <= 1'b0;
            r_rx_sh   <= {MISO, r_rx_sh[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'(FRAME_BITS - 1)) begin
              r_write_en <= 1'b0;
              r_read_en  <= 1'b0;
              r_mosi     <= 1'b0;
              r_state    <= ST_FLUSH;
            end else begin
              r_mosi  <= r_tx_sh[7];
              r_tx_sh <= {r_tx_sh[6:0], 1'b0};
              r_state <= ST_LOW;
            end
          end
        end
        ST_FLUSH: begin
          // sclk level distinguishes the flush rise from the closing flush fall.
          if (w_tick) begin
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else begin
              r_sclk   <= 1'b0;
              r_select <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              if (r_rd) begin
                r_rx_data <= r_rx_sh;
              end
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign rx_data  = r_rx_data;
  assign sclk     = r_sclk;
  assign select   = r_select;
  assign write_en = r_write_en;
  assign read_en  = r_read_en;
  assign MOSI     = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: two instances (CLK_DIV=2 and 1), each with an SPI slave model.
module tb_spi_master;

  typedef struct {
    int          inst;
    logic [7:0]  rx;
    logic [7:0]  sout;
    int unsigned done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance 0 (CLK_DIV=2)
  logic       start0 = 1'b0, wr0 = 1'b0, rd0 = 1'b0;
  logic [7:0] tx0 = '0;
  logic       busy0, done0, sclk0, sel0, we0, re0, mosi0;
  logic [7:0] rx0;
  logic       miso0 = 1'b0;
  logic [7:0] din0 = '0, sout0 = '0;
  logic [2:0] sct0 = '0;

  // instance 1 (CLK_DIV=1)
  logic       start1 = 1'b0, wr1 = 1'b0, rd1 = 1'b0;
  logic [7:0] tx1 = '0;
  logic       busy1, done1, sclk1, sel1, we1, re1, mosi1;
  logic [7:0] rx1;
  logic       miso1 = 1'b0;
  logic [7:0] din1 = '0, sout1 = '0;
  logic [2:0] sct1 = '0;

  spi_master #(.CLK_DIV(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .wr_req(wr0), .rd_req(rd0),
    .tx_data(tx0), .busy(busy0), .done(done0), .rx_data(rx0), .sclk(sclk0),
    .select(sel0), .write_en(we0), .read_en(re0), .MOSI(mosi0), .MISO(miso0)
  );

  spi_master #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .wr_req(wr1), .rd_req(rd1),
    .tx_data(tx1), .busy(busy1), .done(done1), .rx_data(rx1), .sclk(sclk1),
    .select(sel1), .write_en(we1), .read_en(re1), .MOSI(mosi1), .MISO(miso1)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;
  exp_t        sbq[$];
  logic [7:0]  m_rx   [2];
  logic [7:0]  m_sout [2];
  int          done_seen0 = 0, done_seen1 = 0;
  logic        pd0 = 1'b0, pd1 = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // cycle counter, advanced on every active edge
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // slave model 0: captures MOSI and drives MISO on sclk rise; a rise with both enables low clears its bit index
  initial forever begin
    @(posedge sclk0 or negedge rst_n);
    if (!rst_n) begin
      sct0 = '0; sout0 = '0; miso0 = 1'b0;
    end else if (sel0) begin
      if (we0 || re0) begin
        if (we0) sout0[3'd7 - sct0] = mosi0;
        if (re0) miso0 = din0[sct0];
        sct0 = sct0 + 3'd1;
      end else begin
        sct0 = '0;
      end
    end
  end

  // slave model 1
  initial forever begin
    @(posedge sclk1 or negedge rst_n);
    if (!rst_n) begin
      sct1 = '0; sout1 = '0; miso1 = 1'b0;
    end else if (sel1) begin
      if (we1 || re1) begin
        if (we1) sout1[3'd7 - sct1] = mosi1;
        if (re1) miso1 = din1[sct1];
        sct1 = sct1 + 3'd1;
      end else begin
        sct1 = '0;
      end
    end
  end

  task automatic score(input int idx, input logic [7:0] rx, input logic bsy, input logic [7:0] sout);
    exp_t e;
    if (sbq.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL spurious_done inst%0d: got done=1 expected no pending frame", idx);
    end else begin
      e = sbq.pop_front();
      chk("frame_inst", 32'(idx), 32'(e.inst));
      chk("rx_data", 32'(rx), 32'(e.rx));
      chk("slave_data_out", 32'(sout), 32'(e.sout));
      chk("done_latency", cyc, e.done_cyc);
      chk("busy_in_done", 32'(bsy), 32'd0);
    end
  endtask

  // monitor: every done pulse is checked against the oldest expectation
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (pd0) chk("done_pulse0", 32'(done0), 32'd0);
      if (pd1) chk("done_pulse1", 32'(done1), 32'd0);
      if (done0) begin
        done_seen0++;
        score(0, rx0, busy0, sout0);
      end
      if (done1) begin
        done_seen1++;
        score(1, rx1, busy1, sout1);
      end
    end
    pd0 = rst_n && done0;
    pd1 = rst_n && done1;
  end

  // Waits for the chosen instance to be idle, requests a frame, and records its expected outcome.
  task automatic issue(input int idx, input logic [7:0] tx, input logic [7:0] din,
                       input logic wr, input logic rd);
    int unsigned d;
    int          w;
    exp_t        e;
    d = (idx == 0) ? 2 : 1;
    w = 0;
    @(negedge clk);
    while (((idx == 0) ? busy0 : busy1) !== 1'b0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout inst%0d: got busy=1 for 200 clks expected 0", idx);
    end
    if (idx == 0) begin
      tx0 = tx; din0 = din; wr0 = wr; rd0 = rd; start0 = 1'b1;
    end else begin
      tx1 = tx; din1 = din; wr1 = wr; rd1 = rd; start1 = 1'b1;
    end
    if (wr) m_sout[idx] = tx;
    if (rd) m_rx[idx] = din;
    e.inst     = idx;
    e.rx       = m_rx[idx];
    e.sout     = m_sout[idx];
    e.done_cyc = cyc + 1 + 18 * d;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (idx == 0) begin
      start0 = 1'b0;
      chk("busy_after_accept0", 32'(busy0), 32'd1);
    end else begin
      start1 = 1'b0;
      chk("busy_after_accept1", 32'(busy1), 32'd1);
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sbq.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d frames outstanding expected 0", sbq.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ds;
    int prev;
    int idx;
    m_rx[0] = '0; m_rx[1] = '0;
    m_sout[0] = '0; m_sout[1] = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs0", 32'({busy0, done0, rx0, sclk0, sel0, we0, re0, mosi0}), 32'd0);
    chk("reset_outputs1", 32'({busy1, done1, rx1, sclk1, sel1, we1, re1, mosi1}), 32'd0);
    rst_n = 1'b1;

    // write-only frame
    issue(0, 8'hA5, 8'($urandom), 1'b1, 1'b0);
    drain();

    // read-only frame
    issue(0, 8'($urandom), 8'h3C, 1'b0, 1'b1);
    drain();

    // full duplex, back to back
    repeat (3) issue(0, 8'h81, 8'h7E, 1'b1, 1'b1);
    drain();

    // no request bits: frame still runs, nothing moves
    issue(0, 8'h42, 8'h99, 1'b0, 1'b0);
    drain();

    // start while busy is ignored
    ds = done_seen0;
    issue(0, 8'h96, 8'h5B, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    tx0 = 8'h00; wr0 = 1'b0; rd0 = 1'b1; start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    drain();
    repeat (40) @(negedge clk);
    chk("single_done", 32'(done_seen0 - ds), 32'd1);

    // asynchronous reset around bit 4, then a fresh frame
    issue(0, 8'h5A, 8'hC3, 1'b1, 1'b1);
    repeat (18) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mid_frame0", 32'({busy0, done0, rx0, sclk0, sel0, we0, re0, mosi0}), 32'd0);
    chk("reset_mid_frame1", 32'({busy1, done1, rx1, sclk1, sel1, we1, re1, mosi1}), 32'd0);
    sbq.delete();
    m_rx[0] = '0; m_rx[1] = '0;
    m_sout[0] = '0; m_sout[1] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(0, 8'hFF, 8'($urandom), 1'b1, 1'b0);
    drain();

    // CLK_DIV=1 full duplex, back to back
    repeat (3) issue(1, 8'h81, 8'h7E, 1'b1, 1'b1);
    drain();

    // randomized frames on both instances
    prev = 0;
    for (int i = 0; i < 24; i++) begin
      idx = (i % 4 == 3) ? 1 : 0;
      if (idx != prev || $urandom_range(0, 2) == 0) drain();
      issue(idx, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      prev = idx;
    end
    drain();
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
